// File: rtl/mem_io_unit.sv
// Memory I/O unit: runs one load/store per memory-stage request on a valid/ready bus and stalls the pipeline until it completes.
// Optional bus wait timeout is enabled by defining MEM_IO_TIMEOUT_EN.
module mem_io_unit #(
  parameter int ADDR_W         = 17,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [1:0]        req_be,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] address,
  input  logic [15:0]       mem_write_data,
  output logic [15:0]       mem_read_data,
  output logic              stall,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_we,
  output logic [1:0]        bus_be,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [15:0]       bus_wdata,
  input  logic              bus_rvalid,
  input  logic [15:0]       bus_rdata,
  output logic              bus_error
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic              r_busWe;
  logic              r_signed;
  logic [1:0]        r_busBe;
  logic [ADDR_W-1:0] r_busAddr;
  logic [15:0]       r_busWdata;
  logic [15:0]       r_readData;
  logic              w_request;
  logic              w_capture;
  logic              w_abort;

  // Both rd and wr high is treated as a store because r_busWe follows req_wr.
  function automatic logic [15:0] formatRead(input logic [1:0] be, input logic sgn,
                                             input logic [15:0] data);
    logic [7:0] lane;
    lane = be[0] ? data[7:0] : data[15:8];
    if (be == 2'b11) return data;
    return {{8{sgn & lane[7]}}, lane};
  endfunction

  assign w_request = (req_rd | req_wr) & (req_be != 2'b00);
  assign w_capture = ~r_busWe & bus_rvalid &
                     (((r_state == REQ) & bus_ready) | (r_state == RESP));

`ifdef MEM_IO_TIMEOUT_EN
  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT_CYCLES);
  logic [7:0] r_waitCnt;
  logic       r_busError;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_waitCnt <= 8'd0;
    end else if ((w_nextState == REQ || w_nextState == RESP) && w_nextState != r_state) begin
      r_waitCnt <= 8'd0;
    end else if (r_state == REQ || r_state == RESP) begin
      r_waitCnt <= r_waitCnt + 8'd1;
    end
  end

  // A completing handshake in the expiry cycle wins over the abort.
  assign w_abort = (r_waitCnt == LP_TIMEOUT) &
                   (((r_state == REQ) & ~bus_ready) | ((r_state == RESP) & ~bus_rvalid));

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) r_busError <= 1'b0;
    else         r_busError <= w_abort;
  end
  assign bus_error = r_busError;
`else
  assign w_abort   = 1'b0;
  assign bus_error = 1'b0;
`endif

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) r_state <= IDLE;
    else         r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (w_request) w_nextState = REQ;
      REQ: begin
        if (bus_ready)    w_nextState = (r_busWe | bus_rvalid) ? DONE : RESP;
        else if (w_abort) w_nextState = DONE;
      end
      RESP: if (bus_rvalid | w_abort) w_nextState = DONE;
      DONE: w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Stall must rise in the request's first cycle, hence the combinational IDLE term.
  always_comb begin
    stall     = 1'b0;
    bus_valid = 1'b0;
    case (r_state)
      IDLE: stall = w_request;
      REQ: begin
        stall     = 1'b1;
        bus_valid = 1'b1;
      end
      RESP: stall = 1'b1;
      default: begin
        stall     = 1'b0;
        bus_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_busWe    <= 1'b0;
      r_signed   <= 1'b0;
      r_busBe    <= 2'b00;
      r_busAddr  <= '0;
      r_busWdata <= 16'h0000;
      r_readData <= 16'h0000;
    end else begin
      if (r_state == IDLE && w_request) begin
        r_busWe    <= req_wr;
        r_signed   <= req_signed;
        r_busBe    <= req_be;
        r_busAddr  <= address;
        r_busWdata <= mem_write_data;
      end
      if (w_capture)
        r_readData <= formatRead(r_busBe, r_signed, bus_rdata);
      else if (w_abort && !r_busWe)
        r_readData <= 16'h0000;
    end
  end

  assign bus_we        = r_busWe;
  assign bus_be        = r_busBe;
  assign bus_addr      = r_busAddr;
  assign bus_wdata     = r_busWdata;
  assign mem_read_data = r_readData;

endmodule
